// File: rtl/countdown_timer.sv
// Microwave-style MM:SS countdown timer with keypad load, start/stop/pause and done pulse.
// Optional door interlock is enabled by defining TIMER_DOOR_INTERLOCK_EN.
module countdown_timer (
   input  logic       clk,
   input  logic       clear,
   input  logic [3:0] D,
   input  logic       loadn,
   input  logic       pgt_1Hz,
   input  logic       start,
   input  logic       stop,
   input  logic       door_closed,
   output logic [3:0] mins,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       mag_on,
   output logic       done,
   output logic       zero,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] mins_q, mins_d;
   logic [3:0] tens_q, tens_d;
   logic [3:0] ones_q, ones_d;
   logic       done_q, done_d;
   logic       loadn_q, tick_q, start_q, stop_q;

   logic       load_ev, tick_ev, start_ev, stop_ev, load_ok;
   logic       door_ok, zero_w;
   logic [3:0] dec_m, dec_t, dec_o;
   logic       dec_zero;

`ifdef TIMER_DOOR_INTERLOCK_EN
   assign door_ok = door_closed;
`else
   logic unused_door;
   assign unused_door = door_closed;
   assign door_ok     = 1'b1;
`endif

   assign load_ev  = loadn_q & ~loadn;
   assign tick_ev  = ~tick_q & pgt_1Hz;
   assign start_ev = ~start_q & start;
   assign stop_ev  = ~stop_q & stop;
   assign load_ok  = load_ev && (D <= 4'd9);
   assign zero_w   = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);

   // One-second borrow chain; tens digits above 5 are counted literally.
   always_comb begin
      dec_m = mins_q;
      dec_t = tens_q;
      dec_o = ones_q;
      if (ones_q != 4'd0) begin
         dec_o = ones_q - 4'd1;
      end else if (tens_q != 4'd0) begin
         dec_o = 4'd9;
         dec_t = tens_q - 4'd1;
      end else begin
         dec_o = 4'd9;
         dec_t = 4'd5;
         dec_m = mins_q - 4'd1;
      end
      dec_zero = (dec_m == 4'd0) && (dec_t == 4'd0) && (dec_o == 4'd0);
   end

   always_comb begin
      state_d = state_q;
      mins_d  = mins_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE, PAUSE: begin
            // stop beats start; an accepted start swallows a coincident load
            if (stop_ev) begin
               state_d = IDLE;
               mins_d  = 4'd0;
               tens_d  = 4'd0;
               ones_d  = 4'd0;
            end else if (start_ev && !zero_w && door_ok) begin
               state_d = RUN;
            end else if (load_ok) begin
               mins_d = tens_q;
               tens_d = ones_q;
               ones_d = D;
            end
         end
         RUN: begin
            if (stop_ev || !door_ok) begin
               state_d = PAUSE;
            end else if (tick_ev) begin
               mins_d = dec_m;
               tens_d = dec_t;
               ones_d = dec_o;
               if (dec_zero) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         DONE: begin
            if (stop_ev) begin
               state_d = IDLE;
               mins_d  = 4'd0;
               tens_d  = 4'd0;
               ones_d  = 4'd0;
            end else if (load_ok) begin
               state_d = IDLE;
               mins_d  = tens_q;
               tens_d  = ones_q;
               ones_d  = D;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q <= IDLE;
         mins_q  <= 4'd0;
         tens_q  <= 4'd0;
         ones_q  <= 4'd0;
         done_q  <= 1'b0;
         loadn_q <= 1'b1;
         tick_q  <= 1'b0;
         start_q <= 1'b0;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mins_q  <= mins_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         done_q  <= done_d;
         loadn_q <= loadn;
         tick_q  <= pgt_1Hz;
         start_q <= start;
         stop_q  <= stop;
      end
   end

   assign mins      = mins_q;
   assign sec_tens  = tens_q;
   assign sec_ones  = ones_q;
   assign mag_on    = (state_q == RUN);
   assign done      = done_q;
   assign zero      = zero_w;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed scoreboard bench for countdown_timer; each step queues the expected
// {state, mins, tens, ones, mag_on, done, zero} and compares after the clock edge.
module tb_countdown_timer;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic       clk = 1'b0;
   logic       clear, loadn, pgt_1Hz, start, stop, door_closed;
   logic [3:0] D;
   logic [3:0] mins, sec_tens, sec_ones;
   logic       mag_on, done, zero;
   logic [1:0] state_dbg;

   logic [16:0] exp_q[$];
   string       tag_q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   countdown_timer dut (
      .clk         (clk),
      .clear       (clear),
      .D           (D),
      .loadn       (loadn),
      .pgt_1Hz     (pgt_1Hz),
      .start       (start),
      .stop        (stop),
      .door_closed (door_closed),
      .mins        (mins),
      .sec_tens    (sec_tens),
      .sec_ones    (sec_ones),
      .mag_on      (mag_on),
      .done        (done),
      .zero        (zero),
      .state_dbg   (state_dbg)
   );

   always #5 clk = ~clk;

   // Expected vector from the bench's view of the timer: mag_on only in RUN, zero when all digits are 0.
   function automatic logic [16:0] ex(input logic [1:0] s, input logic [3:0] m,
                                      input logic [3:0] t, input logic [3:0] o,
                                      input logic dn);
      logic z;
      z = (m == 4'd0) && (t == 4'd0) && (o == 4'd0);
      return {s, m, t, o, (s == S_RUN), dn, z};
   endfunction

   // Queue an expectation, clock once, then pop and compare 1 time unit after the edge.
   task automatic step(input string tag, input logic [16:0] e);
      logic [16:0] obs, want;
      string       t;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      obs  = {state_dbg, mins, sec_tens, sec_ones, mag_on, done, zero};
      want = exp_q.pop_front();
      t    = tag_q.pop_front();
      n_checks++;
      assert (obs === want) else begin
         n_errors++;
         $error("FAIL %s observed st=%0d %0d:%0d%0d mag=%b done=%b zero=%b expected st=%0d %0d:%0d%0d mag=%b done=%b zero=%b",
                t, obs[16:15], obs[14:11], obs[10:7], obs[6:3], obs[2], obs[1], obs[0],
                want[16:15], want[14:11], want[10:7], want[6:3], want[2], want[1], want[0]);
      end
   endtask

   task automatic load_key(input logic [3:0] d, input string tag, input logic [16:0] e);
      loadn = 1'b0;
      D     = d;
      step(tag, e);
      loadn = 1'b1;
      step({tag, "_rel"}, e);
   endtask

   task automatic pulse(input logic st, input logic sp, input logic tk,
                        input string tag, input logic [16:0] e);
      start   = st;
      stop    = sp;
      pgt_1Hz = tk;
      step(tag, e);
      start   = 1'b0;
      stop    = 1'b0;
      pgt_1Hz = 1'b0;
      step({tag, "_rel"}, e);
   endtask

   initial begin
      logic [3:0] bad_d;
      clear       = 1'b1;
      loadn       = 1'b1;
      D           = 4'd0;
      pgt_1Hz     = 1'b0;
      start       = 1'b0;
      stop        = 1'b0;
      door_closed = 1'b1;

      step("reset0", ex(S_IDLE, 0, 0, 0, 0));
      step("reset1", ex(S_IDLE, 0, 0, 0, 0));
      clear = 1'b0;

      // Keypad shift-in and rejection of non-BCD digits
      load_key(4'd1, "ld1", ex(S_IDLE, 0, 0, 1, 0));
      load_key(4'd3, "ld3", ex(S_IDLE, 0, 1, 3, 0));
      load_key(4'd0, "ld0", ex(S_IDLE, 1, 3, 0, 0));
      bad_d = 4'($urandom_range(10, 15));
      load_key(bad_d, "ld_bad", ex(S_IDLE, 1, 3, 0, 0));
      pulse(1'b0, 1'b1, 1'b0, "stop_idle", ex(S_IDLE, 0, 0, 0, 0));
      pulse(1'b1, 1'b0, 1'b0, "start_at_zero", ex(S_IDLE, 0, 0, 0, 0));

      // Countdown 00:03 to DONE
      load_key(4'd0, "cd_ld0a", ex(S_IDLE, 0, 0, 0, 0));
      load_key(4'd0, "cd_ld0b", ex(S_IDLE, 0, 0, 0, 0));
      load_key(4'd3, "cd_ld3", ex(S_IDLE, 0, 0, 3, 0));
      pulse(1'b1, 1'b0, 1'b0, "cd_start", ex(S_RUN, 0, 0, 3, 0));
      load_key(4'd7, "ld_in_run", ex(S_RUN, 0, 0, 3, 0));
      pulse(1'b0, 1'b0, 1'b1, "cd_tick1", ex(S_RUN, 0, 0, 2, 0));
      pulse(1'b0, 1'b0, 1'b1, "cd_tick2", ex(S_RUN, 0, 0, 1, 0));
      pgt_1Hz = 1'b1;
      step("cd_tick3_done", ex(S_DONE, 0, 0, 0, 1));
      pgt_1Hz = 1'b0;
      step("cd_done_low", ex(S_DONE, 0, 0, 0, 0));
      pulse(1'b0, 1'b0, 1'b1, "tick_in_done", ex(S_DONE, 0, 0, 0, 0));
      pulse(1'b1, 1'b0, 1'b0, "start_in_done", ex(S_DONE, 0, 0, 0, 0));

      // Borrow from 1:00, load straight out of DONE
      load_key(4'd1, "br_ld1", ex(S_IDLE, 0, 0, 1, 0));
      load_key(4'd0, "br_ld0a", ex(S_IDLE, 0, 1, 0, 0));
      load_key(4'd0, "br_ld0b", ex(S_IDLE, 1, 0, 0, 0));
      pulse(1'b1, 1'b0, 1'b0, "br_start", ex(S_RUN, 1, 0, 0, 0));
      pulse(1'b0, 1'b0, 1'b1, "br_tick", ex(S_RUN, 0, 5, 9, 0));
      pulse(1'b0, 1'b1, 1'b0, "br_stop1", ex(S_PAUSE, 0, 5, 9, 0));
      pulse(1'b0, 1'b1, 1'b0, "br_stop2", ex(S_IDLE, 0, 0, 0, 0));

      // Clear mid-run at 2:00 with a coincident tick
      load_key(4'd2, "cl_ld2", ex(S_IDLE, 0, 0, 2, 0));
      load_key(4'd0, "cl_ld0a", ex(S_IDLE, 0, 2, 0, 0));
      load_key(4'd0, "cl_ld0b", ex(S_IDLE, 2, 0, 0, 0));
      pulse(1'b1, 1'b0, 1'b0, "cl_start", ex(S_RUN, 2, 0, 0, 0));
      clear   = 1'b1;
      pgt_1Hz = 1'b1;
      step("cl_clear", ex(S_IDLE, 0, 0, 0, 0));
      clear   = 1'b0;
      pgt_1Hz = 1'b0;
      step("cl_after", ex(S_IDLE, 0, 0, 0, 0));

      // Priority: stop beats tick in RUN, stop beats start in PAUSE
      load_key(4'd0, "pr_ld0a", ex(S_IDLE, 0, 0, 0, 0));
      load_key(4'd0, "pr_ld0b", ex(S_IDLE, 0, 0, 0, 0));
      load_key(4'd5, "pr_ld5", ex(S_IDLE, 0, 0, 5, 0));
      pulse(1'b1, 1'b0, 1'b0, "pr_start", ex(S_RUN, 0, 0, 5, 0));
      pulse(1'b0, 1'b1, 1'b1, "pr_stop_tick", ex(S_PAUSE, 0, 0, 5, 0));
      pulse(1'b0, 1'b0, 1'b1, "pr_tick_pause", ex(S_PAUSE, 0, 0, 5, 0));
      load_key(4'd7, "pr_ld_pause", ex(S_PAUSE, 0, 5, 7, 0));
      pulse(1'b1, 1'b0, 1'b0, "pr_resume", ex(S_RUN, 0, 5, 7, 0));
      pulse(1'b0, 1'b0, 1'b1, "pr_tick", ex(S_RUN, 0, 5, 6, 0));
      pulse(1'b0, 1'b1, 1'b0, "pr_pause", ex(S_PAUSE, 0, 5, 6, 0));
      pulse(1'b1, 1'b1, 1'b0, "pr_stop_start", ex(S_IDLE, 0, 0, 0, 0));

      // Literal tens above 5: 1:90
      load_key(4'd1, "lt_ld1", ex(S_IDLE, 0, 0, 1, 0));
      load_key(4'd9, "lt_ld9", ex(S_IDLE, 0, 1, 9, 0));
      load_key(4'd0, "lt_ld0", ex(S_IDLE, 1, 9, 0, 0));
      pulse(1'b1, 1'b0, 1'b0, "lt_start", ex(S_RUN, 1, 9, 0, 0));
      pulse(1'b0, 1'b0, 1'b1, "lt_tick", ex(S_RUN, 1, 8, 9, 0));

`ifdef TIMER_DOOR_INTERLOCK_EN
      door_closed = 1'b0;
      pgt_1Hz     = 1'b1;
      step("door_open", ex(S_PAUSE, 1, 8, 9, 0));
      pgt_1Hz     = 1'b0;
      step("door_open_hold", ex(S_PAUSE, 1, 8, 9, 0));
      pulse(1'b1, 1'b0, 1'b0, "start_door_open", ex(S_PAUSE, 1, 8, 9, 0));
      door_closed = 1'b1;
      pulse(1'b1, 1'b0, 1'b0, "start_door_closed", ex(S_RUN, 1, 8, 9, 0));
`else
      door_closed = 1'b0;
      pulse(1'b0, 1'b0, 1'b1, "door_ignored", ex(S_RUN, 1, 8, 8, 0));
      door_closed = 1'b1;
`endif

      pulse(1'b0, 1'b1, 1'b0, "end_pause", ex(S_PAUSE, mins, sec_tens, sec_ones, 0));
      pulse(1'b0, 1'b1, 1'b0, "end_idle", ex(S_IDLE, 0, 0, 0, 0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 clear  input  1  synchronous, active-high reset.
REQ-004 D  input  4  BCD digit from the keypad encoder; valid while loadn is low.
REQ-005 loadn  input  1  active-low key strobe from the keypad encoder.
REQ-006 pgt_1Hz  input  1  1 Hz tick level, sampled in the clk domain.
REQ-007 start  input  1  start/resume request; rising-edge detected.
REQ-008 stop  input  1  pause/cancel request; rising-edge detected.
REQ-009 door_closed  input  1  door switch, 1 = closed.
REQ-010 mins  output  4  minutes digit, BCD.
REQ-011 sec_tens  output  4  tens-of-seconds digit.
REQ-012 sec_ones  output  4  units-of-seconds digit.
REQ-013 mag_on  output  1  magnetron enable; 1 only in state RUN.
REQ-014 done  output  1  one-cycle pulse on entry to state DONE.
REQ-015 zero  output  1  1 when mins, sec_tens and sec_ones are all 0.

Function
REQ-016 The block SHALL register loadn, pgt_1Hz, start and stop once, and detect events from the registered value against the current value:
- load event: 1 to 0 transition on loadn.
- tick, start and stop events: 0 to 1 transitions.
REQ-017 The FSM SHALL have four states: IDLE, RUN, PAUSE, DONE.
REQ-018 A load event in IDLE or PAUSE with D <= 9 SHALL shift the digits in the same edge: mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=D.
- The old mins value is discarded.
REQ-019 A load event with D > 9, or in state RUN, SHALL be ignored.
REQ-020 A load event in DONE SHALL move the FSM to IDLE and shift D in as in REQ-018.
REQ-021 A start event in IDLE or PAUSE with zero=0 and the door enabled SHALL move the FSM to RUN.
- Otherwise the start event SHALL be ignored.
REQ-022 A tick event in RUN SHALL decrement the digits by one second:
- if sec_ones>0: decrement sec_ones.
- else if sec_tens>0: sec_ones=9, decrement sec_tens.
- else: sec_ones=9, sec_tens=5, decrement mins.
REQ-023 Entered values with sec_tens > 5 SHALL be accepted and counted literally (1:90 counts 150 s).
REQ-024 When a decrement yields 00:00, the FSM SHALL enter DONE on the same edge.
- done SHALL be 1 for exactly the following cycle.
REQ-025 A stop event in RUN SHALL move the FSM to PAUSE and keep the digits.
REQ-026 A stop event in PAUSE, IDLE or DONE SHALL zero all digits and move the FSM to IDLE.
REQ-027 When stop and start events occur in the same cycle, stop SHALL win.
REQ-028 When stop and tick events occur in the same cycle in RUN, stop SHALL win and no decrement SHALL occur.
REQ-029 Tick events outside RUN SHALL have no effect.
REQ-030 Outputs SHALL be registered or decoded from registers only, with no combinational path from inputs.

Reset
REQ-031 While clear=1, the block SHALL set the state to IDLE, all digits to 0, mag_on=0, done=0 and zero=1.
REQ-032 While clear=1, the block SHALL load all edge-detect registers with their inactive values: loadn=1, others=0.
REQ-033 Asserting clear mid-RUN SHALL drop mag_on on the same edge and discard any pending event.

Configuration
REQ-034 With macro TIMER_DOOR_INTERLOCK_EN defined, the door SHALL be enabled only when door_closed=1.
- door_closed=0 in RUN SHALL force PAUSE on the next edge.
- That PAUSE transition SHALL have priority over tick.
REQ-035 Without TIMER_DOOR_INTERLOCK_EN, the door_closed port SHALL remain present but be ignored, and the door SHALL be treated as always enabled.

Verification
REQ-036 Load sequence: load strobes with D=1,3,0 -> mins=1, sec_tens=3, sec_ones=0; then load D=12 -> digits unchanged.
REQ-037 Countdown: load 0,0,3, then start, then 3 ticks -> digits step 00:03, 00:02, 00:01, 00:00; done pulses once; state DONE; mag_on=0.
REQ-038 Borrow: load 1,0,0 (1:00), start, 1 tick -> mins=0, sec_tens=5, sec_ones=9.
REQ-039 Priority: in RUN at 00:05, stop and tick in the same cycle -> PAUSE at 00:05; second stop -> IDLE at 00:00.
REQ-040 Interlock (macro defined): RUN at 00:10, door_closed=0 -> PAUSE and mag_on=0; start with door open -> stays PAUSE; close the door and start -> RUN.
REQ-041 Reset mid-run: RUN at 02:00, clear for 1 cycle -> IDLE, digits 0, zero=1, no done pulse.
